// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared widths and register index constants for the integer file
package msrv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] X0_IDX = 5'd0;
   localparam logic [REG_ADDR_W-1:0] X2_IDX = 5'd2;

   typedef logic [XLEN-1:0]       xword_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // True for any architectural register that actually has storage behind it.
   function automatic logic is_stored(input reg_addr_t addr);
      return addr != X0_IDX;
   endfunction

endpackage

// File: rtl/msrv32_if_read_port.sv
// rtl/msrv32_if_read_port.sv - combinational read port with x0 forcing and write-through bypass
module msrv32_if_read_port
   import msrv32_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]       regs [1:NUM_REGS-1],
   input  logic                  byp_en,
   input  logic [REG_ADDR_W-1:0] byp_addr,
   input  logic [XLEN-1:0]       byp_data,
   output logic [XLEN-1:0]       data
);

   // x0 always reads zero; otherwise the in-flight write wins over the stored copy.
   always_comb begin
      data = '0;
      if (is_stored(addr)) begin
         if (byp_en && (addr == byp_addr)) begin
            data = byp_data;
         end else begin
            data = regs[addr];
         end
      end
   end

endmodule

// File: rtl/msrv32_integer_file.sv
// rtl/msrv32_integer_file.sv - 31x32 integer register file, two read ports, one write port
module msrv32_integer_file
   import msrv32_pkg::*;
#(
   parameter logic [XLEN-1:0] SP_RESET        = 32'h0000_3FFC,
   parameter bit              GLOBAL_STALL_EN = 1'b1
)(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
   input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
   input  logic [REG_ADDR_W-1:0] rd_addr_in,
   input  logic                  wr_en_in,
   input  logic [XLEN-1:0]       rd_in,
   input  logic                  stall_in,
   input  logic                  flush_in,
   output logic [XLEN-1:0]       rs_1_out,
   output logic [XLEN-1:0]       rs_2_out,
   output logic                  wr_ack_out
);

   // x0 has no storage; index range starts at x1.
   logic [XLEN-1:0] regs [1:NUM_REGS-1];

   logic stall_gate;
   logic we_eff;
   logic byp_en;

   assign stall_gate = stall_in & GLOBAL_STALL_EN;
   assign we_eff     = wr_en_in & ~flush_in & ~stall_gate & is_stored(rd_addr_in);
   // A write presented during reset is dropped, so it must not be forwarded either.
   assign byp_en     = we_eff & ~rst_in;

   // Array update: reset loads zeros and the stack pointer, otherwise the qualified write lands.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         regs[X2_IDX] <= SP_RESET;
      end else if (we_eff) begin
         regs[rd_addr_in] <= rd_in;
      end
   end

   // Write acknowledge: one-cycle pulse following each effective write.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ack_out <= 1'b0;
      end else begin
         wr_ack_out <= we_eff;
      end
   end

   msrv32_if_read_port u_read_port_1 (
      .addr     (rs_1_addr_in),
      .regs     (regs),
      .byp_en   (byp_en),
      .byp_addr (rd_addr_in),
      .byp_data (rd_in),
      .data     (rs_1_out)
   );

   msrv32_if_read_port u_read_port_2 (
      .addr     (rs_2_addr_in),
      .regs     (regs),
      .byp_en   (byp_en),
      .byp_addr (rd_addr_in),
      .byp_data (rd_in),
      .data     (rs_2_out)
   );

endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb/tb_msrv32_integer_file.sv - randomized reference-model bench for msrv32_integer_file
module tb_msrv32_integer_file;

   localparam logic [31:0] SP = 32'h0000_3FFC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  rs1_a = '0, rs2_a = '0, rd_a = '0;
   logic        wen = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rs1_d, rs2_d;
   logic        ack;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] model [0:31];
   logic        model_valid = 1'b0;
   logic        exp_ack = 1'b0;

   always #5 clk = ~clk;

   msrv32_integer_file dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .rs_1_addr_in (rs1_a),
      .rs_2_addr_in (rs2_a),
      .rd_addr_in   (rd_a),
      .wr_en_in     (wen),
      .rd_in        (wdata),
      .stall_in     (stall),
      .flush_in     (flush),
      .rs_1_out     (rs1_d),
      .rs_2_out     (rs2_d),
      .wr_ack_out   (ack)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic r, input logic w,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'h0;
      if (!r && w && a == wa) return wd;
      return model[a];
   endfunction

   // One cycle: drive at negedge, check mid-low-phase, advance the model for the coming edge.
   task automatic step(input logic r, input logic w, input logic s, input logic f,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
      logic we;
      @(negedge clk);
      rst = r; wen = w; stall = s; flush = f;
      rd_a = wa; wdata = wd; rs1_a = a1; rs2_a = a2;
      #2;
      we = w && !f && !s && (wa != 5'd0);
      if (model_valid) begin
         cmp("rs1", rs1_d, model_read(a1, r, we, wa, wd));
         cmp("rs2", rs2_d, model_read(a2, r, we, wa, wd));
         cmp("ack", {31'h0, ack}, {31'h0, exp_ack});
      end
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         model[2] = SP;
         exp_ack = 1'b0;
         model_valid = 1'b1;
      end else begin
         if (we) model[wa] = wd;
         exp_ack = we;
      end
   endtask

   initial begin
      logic [4:0] wa, a1, a2;
      // reset, then scan every address
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int a = 0; a < 32; a++) begin
         step(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
         cmp("scan_lit", rs1_d, (a == 2) ? 32'h0000_3FFC : 32'h0);
         cmp("scan_ack_lit", {31'h0, ack}, 32'h0);
      end
      // write x5 then read back on both ports
      step(0, 1, 0, 0, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd1);
      step(0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
      cmp("x5_p1_lit", rs1_d, 32'hDEAD_BEEF);
      cmp("x5_p2_lit", rs2_d, 32'hDEAD_BEEF);
      cmp("x5_ack_lit", {31'h0, ack}, 32'h1);
      step(0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd0);
      cmp("x5_ack_drop_lit", {31'h0, ack}, 32'h0);
      // same-cycle bypass on x7
      step(0, 1, 0, 0, 5'd7, 32'h1234_5678, 5'd7, 5'd6);
      cmp("x7_bypass_lit", rs1_d, 32'h1234_5678);
      step(0, 0, 0, 0, 5'd0, 32'h0, 5'd7, 5'd7);
      cmp("x7_hold_lit", rs1_d, 32'h1234_5678);
      // write to x0 discarded
      step(0, 1, 0, 0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      cmp("x0_bypass_lit", rs1_d, 32'h0);
      step(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
      cmp("x0_read_lit", rs1_d, 32'h0);
      cmp("x0_ack_lit", {31'h0, ack}, 32'h0);
      // flush, then stall, both suppress the x9 write
      step(0, 1, 0, 1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9);
      cmp("x9_flush_lit", rs1_d, 32'h0);
      step(0, 1, 1, 0, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9);
      cmp("x9_stall_lit", rs2_d, 32'h0);
      cmp("x9_flush_ack_lit", {31'h0, ack}, 32'h0);
      step(0, 0, 0, 0, 5'd0, 32'h0, 5'd9, 5'd2);
      cmp("x9_hold_lit", rs1_d, 32'h0);
      cmp("x9_stall_ack_lit", {31'h0, ack}, 32'h0);
      // write during reset ignored, next-cycle write accepted
      step(1, 1, 0, 0, 5'd3, 32'h55, 5'd3, 5'd7);
      cmp("x3_rst_lit", rs1_d, 32'h0);
      step(0, 1, 0, 0, 5'd3, 32'h55, 5'd3, 5'd7);
      cmp("x3_byp_lit", rs1_d, 32'h55);
      cmp("x7_cleared_lit", rs2_d, 32'h0);
      cmp("rst_ack_lit", {31'h0, ack}, 32'h0);
      step(0, 0, 0, 0, 5'd0, 32'h0, 5'd3, 5'd2);
      cmp("x3_stored_lit", rs1_d, 32'h55);
      cmp("sp_lit", rs2_d, 32'h0000_3FFC);
      cmp("x3_ack_lit", {31'h0, ack}, 32'h1);
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         wa = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         step($urandom_range(0, 60) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0,
              wa, $urandom, a1, a2);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
